pointwise_group_accumulator: RTL



---
 rtl/pw_pkg.sv | 41 ++++
 rtl/pointwise_mac_tree.sv | 77 +++++++
 rtl/pointwise_group_accumulator.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pw_pkg.sv
// Shared types, fixed-point constants and the output saturation helper
// for the pointwise (1x1) group accumulator.
package pw_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int FRAC_BITS   = 8;
  localparam int IN_CHANNELS = 32;
  // Wide enough to hold the full sum of IN_CHANNELS products without wrapping.
  localparam int ACC_WIDTH   = 2 * DATA_WIDTH + $clog2(IN_CHANNELS);
  localparam int CH_W        = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Tag travelling alongside each read through the datapath.
  typedef struct packed {
    logic            first;
    logic            last;
    logic [CH_W-1:0] oc;
  } tag_t;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  // Drop the extra fractional bits, then clamp into the DATA_WIDTH signed range.
  function automatic logic [DATA_WIDTH-1:0] sat_shift(input logic signed [ACC_WIDTH-1:0] acc);
    logic signed [ACC_WIDTH-1:0] sh;
    sh = acc >>> FRAC_BITS;
    if (sh > SAT_MAX) begin
      sat_shift = SAT_MAX[DATA_WIDTH-1:0];
    end else if (sh < SAT_MIN) begin
      sat_shift = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      sat_shift = sh[DATA_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/pointwise_mac_tree.sv
// ICP-lane signed multiplier bank followed by a registered adder tree.
// Fixed two-cycle latency; valid and tag ride along unchanged.
module pointwise_mac_tree
  import pw_pkg::*;
#(
  parameter int ICP = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_valid,
  input  tag_t                           i_tag,
  input  logic [DATA_WIDTH*ICP-1:0]      i_act,
  input  logic [DATA_WIDTH*ICP-1:0]      i_wgt,
  output logic                           o_valid,
  output tag_t                           o_tag,
  output logic signed [ACC_WIDTH-1:0]    o_sum
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]        w_prod [ICP];
  logic signed [PW-1:0]        r_prod [ICP];
  logic                        r_v1;
  tag_t                        r_tag1;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic signed [ACC_WIDTH-1:0] r_sum;
  logic                        r_v2;
  tag_t                        r_tag2;

  // Per-lane sign extension to product width so the multiply is full precision.
  for (genvar gi = 0; gi < ICP; gi++) begin : g_lane
    logic signed [PW-1:0] w_a;
    logic signed [PW-1:0] w_w;
    assign w_a = {{DATA_WIDTH{i_act[gi*DATA_WIDTH+DATA_WIDTH-1]}}, i_act[gi*DATA_WIDTH +: DATA_WIDTH]};
    assign w_w = {{DATA_WIDTH{i_wgt[gi*DATA_WIDTH+DATA_WIDTH-1]}}, i_wgt[gi*DATA_WIDTH +: DATA_WIDTH]};
    assign w_prod[gi] = w_a * w_w;
  end

  // Stage 1: register the lane products together with their tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ICP; i++) r_prod[i] <= '0;
      r_v1   <= 1'b0;
      r_tag1 <= '0;
    end else begin
      for (int i = 0; i < ICP; i++) r_prod[i] <= w_prod[i];
      r_v1   <= i_valid;
      r_tag1 <= i_tag;
    end
  end

  // Adder tree over the registered products, each sign-extended to accumulator width.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < ICP; i++) begin
      w_sum = w_sum + {{(ACC_WIDTH-PW){r_prod[i][PW-1]}}, r_prod[i]};
    end
  end

  // Stage 2: register the group sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_v2   <= 1'b0;
      r_tag2 <= '0;
    end else begin
      r_sum  <= w_sum;
      r_v2   <= r_v1;
      r_tag2 <= r_tag1;
    end
  end

  assign o_valid = r_v2;
  assign o_tag   = r_tag2;
  assign o_sum   = r_sum;

endmodule

// File: rtl/pointwise_group_accumulator.sv
// Pointwise 1x1 conv stage: walks (oc, g) reads out of the D2P buffer,
// accumulates ICP-wide MACs across input-channel groups and emits one
// saturated result per output channel, then signals the buffer to flip.
module pointwise_group_accumulator
  import pw_pkg::*;
#(
  parameter  int INCHANNEL_PARALLELISM = 8,
  parameter  int OUT_CHANNELS          = 64,
  parameter  int READ_LATENCY          = 1,
  localparam int ICP                   = INCHANNEL_PARALLELISM,
  localparam int G                     = IN_CHANNELS / ICP,
  localparam int AW                    = $clog2(OUT_CHANNELS * G)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic [7:0]                point_channel_sel,
  input  logic [DATA_WIDTH*ICP-1:0] point_input,
  output logic [AW-1:0]             weight_addr,
  input  logic [DATA_WIDTH*ICP-1:0] weight_in,
  output logic [DATA_WIDTH-1:0]     result,
  output logic                      result_valid,
  output logic [7:0]                result_ch,
  output logic                      point11_channel_done,
  output logic                      busy,
  output logic                      overflow
);

  localparam int OC_W = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
  localparam int G_W  = (G > 1) ? $clog2(G) : 1;

  state_t                      r_state, w_state_next;
  logic [OC_W-1:0]             r_oc, w_oc_next;
  logic [G_W-1:0]              r_g, w_g_next;
  logic                        r_pending, r_overflow;
  logic                        w_g_last, w_oc_last, w_issue, w_accept, w_consume, w_final;
  tag_t                        w_issue_tag;

  logic [READ_LATENCY-1:0]     r_pipe_v;
  tag_t                        r_pipe_tag [READ_LATENCY];

  logic                        w_mac_v;
  tag_t                        w_mac_tag;
  logic signed [ACC_WIDTH-1:0] w_mac_sum;

  logic signed [ACC_WIDTH-1:0] r_acc, w_acc_next;
  logic [DATA_WIDTH-1:0]       r_result;
  logic                        r_result_valid, r_done;
  logic [7:0]                  r_result_ch;

  assign w_g_last  = (r_g == G_W'(G - 1));
  assign w_oc_last = (r_oc == OC_W'(OUT_CHANNELS - 1));
  assign w_issue   = (r_state == S_RUN);
  // Pending counts as busy so a start in the gap before a queued pixel is not taken twice.
  assign busy      = (r_state != S_IDLE) || r_done || r_pending;
  assign w_accept  = start && !busy;
  assign w_consume = (r_state == S_IDLE) && r_pending;

  // State and issue counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_oc    <= '0;
      r_g     <= '0;
    end else begin
      r_state <= w_state_next;
      r_oc    <= w_oc_next;
      r_g     <= w_g_next;
    end
  end

  // Next-state, counter advance and read-address outputs.
  always_comb begin
    w_state_next      = r_state;
    w_oc_next         = r_oc;
    w_g_next          = r_g;
    point_channel_sel = '0;
    weight_addr       = '0;
    w_issue_tag.first = (r_g == '0);
    w_issue_tag.last  = w_g_last;
    w_issue_tag.oc    = CH_W'(r_oc);
    case (r_state)
      S_IDLE: begin
        if (w_accept || r_pending) begin
          w_state_next = S_RUN;
          w_oc_next    = '0;
          w_g_next     = '0;
        end
      end
      S_RUN: begin
        point_channel_sel = 8'(r_g * ICP);
        weight_addr       = AW'(r_oc * G + r_g);
        if (w_g_last) begin
          w_g_next  = '0;
          w_oc_next = r_oc + OC_W'(1);
          if (w_oc_last) begin
            w_state_next = S_DRAIN;
            w_oc_next    = '0;
          end
        end else begin
          w_g_next = r_g + G_W'(1);
        end
      end
      S_DRAIN: begin
        // Leave as the final result is being registered, so a queued pixel
        // can begin issuing on the edge after the done pulse.
        if (w_final) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Queue at most one extra start; any further start is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_pending <= (r_pending && !w_consume) || (start && busy && !r_pending);
      if (start && busy && r_pending) r_overflow <= 1'b1;
    end
  end

  // Tag shift register matching the buffer/weight read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pipe_v[i]   <= 1'b0;
        r_pipe_tag[i] <= '0;
      end
    end else begin
      r_pipe_v[0]   <= w_issue;
      r_pipe_tag[0] <= w_issue_tag;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_v[i]   <= r_pipe_v[i-1];
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
    end
  end

  pointwise_mac_tree #(
    .ICP (ICP)
  ) u_mac_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (r_pipe_v[READ_LATENCY-1]),
    .i_tag   (r_pipe_tag[READ_LATENCY-1]),
    .i_act   (point_input),
    .i_wgt   (weight_in),
    .o_valid (w_mac_v),
    .o_tag   (w_mac_tag),
    .o_sum   (w_mac_sum)
  );

  assign w_acc_next = w_mac_tag.first ? w_mac_sum : (r_acc + w_mac_sum);
  assign w_final    = w_mac_v && w_mac_tag.last && (w_mac_tag.oc == CH_W'(OUT_CHANNELS - 1));

  // Stage 3: accumulate across groups and emit the saturated channel result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_result_ch    <= '0;
      r_done         <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_done         <= 1'b0;
      if (w_mac_v) begin
        r_acc <= w_acc_next;
        if (w_mac_tag.last) begin
          r_result       <= sat_shift(w_acc_next);
          r_result_valid <= 1'b1;
          r_result_ch    <= w_mac_tag.oc;
          r_done         <= w_final;
        end
      end
    end
  end

  assign result               = r_result;
  assign result_valid         = r_result_valid;
  assign result_ch            = r_result_ch;
  assign point11_channel_done = r_done;
  assign overflow             = r_overflow;

endmodule
